// File: rtl/tff_bank_sequencer.sv
// Command-driven sequencer for a bank of toggle flip-flops: clear, preset,
// single step or N-step runs up/down, with per-bit toggle enables exposed.
module tff_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             hold,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] OP_RUN    = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_PRESET = 2'b10;
    localparam logic [1:0] OP_STEP   = 2'b11;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               wrap_q, wrap_d;
    logic               step_en;
    logic               step_dir;
    logic               carry;

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        wrap_d   = 1'b0;
        step_en  = 1'b0;
        step_dir = dir_q;
        t_vec    = '0;
        carry    = 1'b1;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d = cmd_dir;
                    rem_d = cmd_len;
                    case (cmd_op)
                        OP_RUN: begin
                            if (cmd_len == '0) state_d = DONE;
                            else               state_d = RUN;
                        end
                        OP_CLEAR: begin
                            q_d     = '0;
                            state_d = DONE;
                        end
                        OP_PRESET: begin
                            q_d     = '1;
                            state_d = DONE;
                        end
                        OP_STEP: begin
                            step_en  = 1'b1;
                            step_dir = cmd_dir;
                            state_d  = DONE;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            RUN: begin
                if (!hold) begin
                    step_en = 1'b1;
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Ripple the "all lower bits ones (up) / zeros (down)" term; the final
        // carry out means the step rolls over the whole bank.
        if (step_en && !reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                t_vec[i] = carry;
                carry    = carry & (step_dir ? ~q_q[i] : q_q[i]);
            end
            q_d    = q_q ^ t_vec;
            wrap_d = carry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign wrap      = wrap_q;
    assign q         = q_q;

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Directed self-checking bench for tff_bank_sequencer (WIDTH=4, LEN_W=8).
module tb_tff_bank_sequencer;

    localparam int WIDTH = 4;
    localparam int LEN_W = 8;

    localparam logic [1:0] OP_RUN    = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_PRESET = 2'b10;
    localparam logic [1:0] OP_STEP   = 2'b11;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_dir;
    logic [LEN_W-1:0] cmd_len;
    logic             hold;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             wrap;

    int num_checks;
    int num_errors;

    tff_bank_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .hold      (hold),
        .t_vec     (t_vec),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for exactly one edge (it must be accepted there).
    task automatic applyStimulus(input logic [1:0] op, input logic dir,
                                 input logic [LEN_W-1:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dir   = dir;
        cmd_len   = len;
        #1;
        checkOutput("accept_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    logic [3:0] exp_t1 [5];

    initial begin
        num_checks = 0;
        num_errors = 0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = OP_RUN;
        cmd_dir    = 1'b0;
        cmd_len    = '0;
        hold       = 1'b0;
        exp_t1[0]  = 4'b0001;
        exp_t1[1]  = 4'b0011;
        exp_t1[2]  = 4'b0001;
        exp_t1[3]  = 4'b0111;
        exp_t1[4]  = 4'b0001;

        // Reset, with a STEP offered: t_vec must stay zero under reset
        tick();
        tick();
        cmd_valid = 1'b1;
        cmd_op    = OP_STEP;
        #1;
        checkOutput("reset_tvec", 32'(t_vec), 32'd0);
        cmd_valid = 1'b0;
        reset     = 1'b0;
        #1;
        checkOutput("reset_q",     32'(q),         32'd0);
        checkOutput("reset_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset_busy",  32'(busy),      32'd0);
        checkOutput("reset_done",  32'(done),      32'd0);
        checkOutput("reset_wrap",  32'(wrap),      32'd0);

        // RUN up len=5 from 0
        cmd_valid = 1'b1;
        cmd_op    = OP_RUN;
        cmd_dir   = 1'b0;
        cmd_len   = 8'd5;
        #1;
        checkOutput("run5_accept_tvec", 32'(t_vec), 32'd0);
        tick();
        cmd_valid = 1'b0;
        #1;
        checkOutput("run5_busy", 32'(busy), 32'd1);
        checkOutput("run5_q0",   32'(q),    32'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("run5_tvec", 32'(t_vec), 32'(exp_t1[i]));
            checkOutput("run5_ready", 32'(cmd_ready), 32'd0);
            tick();
            checkOutput("run5_q",    32'(q),    32'(i + 1));
            checkOutput("run5_done", 32'(done), (i == 4) ? 32'd1 : 32'd0);
            checkOutput("run5_wrap", 32'(wrap), 32'd0);
        end
        checkOutput("run5_done_tvec", 32'(t_vec), 32'd0);
        tick();
        checkOutput("run5_idle_ready", 32'(cmd_ready), 32'd1);
        checkOutput("run5_idle_done",  32'(done),      32'd0);

        // PRESET then RUN up len=1 wraps to zero
        applyStimulus(OP_PRESET, 1'b0, 8'd0);
        checkOutput("preset_q",    32'(q),    32'hF);
        checkOutput("preset_wrap", 32'(wrap), 32'd0);
        checkOutput("preset_done", 32'(done), 32'd1);
        tick();
        checkOutput("preset_done_end", 32'(done), 32'd0);
        applyStimulus(OP_RUN, 1'b0, 8'd1);
        checkOutput("run1_tvec", 32'(t_vec), 32'hF);
        tick();
        checkOutput("run1_q",    32'(q),    32'd0);
        checkOutput("run1_wrap", 32'(wrap), 32'd1);
        checkOutput("run1_done", 32'(done), 32'd1);
        tick();
        checkOutput("run1_wrap_end", 32'(wrap), 32'd0);
        checkOutput("run1_done_end", 32'(done), 32'd0);

        // CLEAR then RUN down len=3
        applyStimulus(OP_CLEAR, 1'b0, 8'd0);
        checkOutput("clear_q",    32'(q),    32'd0);
        checkOutput("clear_wrap", 32'(wrap), 32'd0);
        tick();
        applyStimulus(OP_RUN, 1'b1, 8'd3);
        checkOutput("down_tvec0", 32'(t_vec), 32'hF);
        tick();
        checkOutput("down_q1",    32'(q),    32'hF);
        checkOutput("down_wrap1", 32'(wrap), 32'd1);
        checkOutput("down_tvec1", 32'(t_vec), 32'h1);
        tick();
        checkOutput("down_q2",    32'(q),    32'hE);
        checkOutput("down_wrap2", 32'(wrap), 32'd0);
        checkOutput("down_tvec2", 32'(t_vec), 32'h3);
        checkOutput("down_done2", 32'(done), 32'd0);
        tick();
        checkOutput("down_q3",    32'(q),    32'hD);
        checkOutput("down_done3", 32'(done), 32'd1);
        tick();

        // RUN up len=4 with a 2-cycle hold after the second step
        applyStimulus(OP_CLEAR, 1'b0, 8'd0);
        tick();
        applyStimulus(OP_RUN, 1'b0, 8'd4);
        tick();
        tick();
        checkOutput("hold_q_pre", 32'(q), 32'd2);
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checkOutput("hold_tvec", 32'(t_vec), 32'd0);
            tick();
            checkOutput("hold_q",    32'(q),    32'd2);
            checkOutput("hold_done", 32'(done), 32'd0);
        end
        hold = 1'b0;
        tick();
        checkOutput("hold_q3",    32'(q),    32'd3);
        checkOutput("hold_done3", 32'(done), 32'd0);
        tick();
        checkOutput("hold_q4",    32'(q),    32'd4);
        checkOutput("hold_done4", 32'(done), 32'd1);
        tick();

        // RUN up len=10, ignored commands while busy, reset at q=3
        applyStimulus(OP_CLEAR, 1'b0, 8'd0);
        tick();
        applyStimulus(OP_RUN, 1'b0, 8'd10);
        tick();
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        #1;
        checkOutput("busy_ready", 32'(cmd_ready), 32'd0);
        tick();
        checkOutput("busy_ignored_q2", 32'(q), 32'd2);
        tick();
        checkOutput("busy_ignored_q3", 32'(q), 32'd3);
        reset = 1'b1;
        #1;
        checkOutput("midrst_tvec", 32'(t_vec), 32'd0);
        tick();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        checkOutput("midrst_q",     32'(q),         32'd0);
        checkOutput("midrst_busy",  32'(busy),      32'd0);
        checkOutput("midrst_done",  32'(done),      32'd0);
        checkOutput("midrst_ready", 32'(cmd_ready), 32'd1);
        tick();
        checkOutput("midrst_after_done", 32'(done), 32'd0);
        checkOutput("midrst_after_q",    32'(q),    32'd0);

        // Reach q=6, RUN len=0, then STEP down
        applyStimulus(OP_RUN, 1'b0, 8'd6);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("to6_q",     32'(q),         32'd6);
        checkOutput("to6_ready", 32'(cmd_ready), 32'd1);
        applyStimulus(OP_RUN, 1'b0, 8'd0);
        checkOutput("len0_q",    32'(q),    32'd6);
        checkOutput("len0_done", 32'(done), 32'd1);
        tick();
        checkOutput("len0_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = OP_STEP;
        cmd_dir   = 1'b1;
        #1;
        checkOutput("step_tvec", 32'(t_vec), 32'h3);
        tick();
        cmd_valid = 1'b0;
        #1;
        checkOutput("step_q",    32'(q),    32'd5);
        checkOutput("step_done", 32'(done), 32'd1);
        checkOutput("step_wrap", 32'(wrap), 32'd0);
        tick();
        checkOutput("step_done_end", 32'(done),      32'd0);
        checkOutput("step_ready",    32'(cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
